// File: rtl/status_scan_ctrl_if.sv
// Status-digit scan bus: enable/load/codes in, multiplexed pattern and select out.
// BLINK exists only when STATUS_SCAN_BLINK_EN is defined.
interface status_scan_ctrl_if #(
   parameter int N_DIG = 4
);
   logic                 EN;
   logic                 LOAD;
   logic [2*N_DIG-1:0]   STD;
`ifdef STATUS_SCAN_BLINK_EN
   logic [N_DIG-1:0]     BLINK;
`endif
   logic [3:0]           STDIG;
   logic [N_DIG-1:0]     DIG_SEL;
   logic                 SCAN_DONE;

`ifdef STATUS_SCAN_BLINK_EN
   modport master (
      output EN, LOAD, STD, BLINK,
      input  STDIG, DIG_SEL, SCAN_DONE
   );
   modport slave (
      input  EN, LOAD, STD, BLINK,
      output STDIG, DIG_SEL, SCAN_DONE
   );
`else
   modport master (
      output EN, LOAD, STD,
      input  STDIG, DIG_SEL, SCAN_DONE
   );
   modport slave (
      input  EN, LOAD, STD,
      output STDIG, DIG_SEL, SCAN_DONE
   );
`endif
endinterface

// File: rtl/status_scan_ctrl.sv
// Time-multiplexed status-digit scanner with blanking slots and frame-done pulse.
// Optional per-digit blink when STATUS_SCAN_BLINK_EN is defined.
module status_scan_ctrl #(
   parameter int N_DIG     = 4,
   parameter int PRESCALE  = 50000,
   parameter int BLANK_CYC = 2
`ifdef STATUS_SCAN_BLINK_EN
   , parameter int BLINK_FRAMES = 16
`endif
) (
   input  logic              CLK,
   input  logic              RST,
   status_scan_ctrl_if.slave bus
);

   localparam int CMAX = (PRESCALE > BLANK_CYC) ? PRESCALE : BLANK_CYC;
   localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
   localparam int IW   = $clog2(N_DIG);

   localparam logic [CW-1:0] C_PRE_END = CW'(PRESCALE - 1);
   localparam logic [CW-1:0] C_BLK_END = CW'(BLANK_CYC - 1);
   localparam logic [IW-1:0] C_IDX_END = IW'(N_DIG - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BLANK,
      S_SHOW
   } state_t;

   state_t               r_state;
   logic [IW-1:0]        r_idx;
   logic [CW-1:0]        r_cnt;
   logic [2*N_DIG-1:0]   r_shadow;
   logic [3:0]           r_stdig;
   logic [N_DIG-1:0]     r_sel;
   logic                 r_done;

   logic [2*N_DIG-1:0]   w_shadow_nxt;
   logic [1:0]           w_code;
   logic [3:0]           w_pat;
   logic [N_DIG-1:0]     w_sel_on;
   logic                 w_dark;

   // A LOAD on the capture edge must reach the decoder in the same cycle
   assign w_shadow_nxt = bus.LOAD ? bus.STD : r_shadow;
   assign w_code       = w_shadow_nxt[{r_idx, 1'b0} +: 2];
   assign w_pat        = {1'b0, ~w_code[1], ~w_code[0], 1'b1};
   assign w_sel_on     = ~(N_DIG'(1) << r_idx);

`ifdef STATUS_SCAN_BLINK_EN
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [FW-1:0] C_FRM_END = FW'(BLINK_FRAMES - 1);

   logic [FW-1:0] r_frm;
   logic          r_phase;

   assign w_dark = r_phase & bus.BLINK[r_idx];
`else
   assign w_dark = 1'b0;
`endif

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_shadow <= '0;
      end else if (bus.LOAD) begin
         r_shadow <= bus.STD;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
         r_cnt   <= '0;
         r_stdig <= 4'b0000;
         r_sel   <= '1;
         r_done  <= 1'b0;
`ifdef STATUS_SCAN_BLINK_EN
         r_frm   <= '0;
         r_phase <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_sel   <= '1;
               r_stdig <= 4'b0000;
               r_idx   <= '0;
               r_cnt   <= '0;
`ifdef STATUS_SCAN_BLINK_EN
               r_frm   <= '0;
               r_phase <= 1'b0;
`endif
               if (bus.EN) r_state <= S_BLANK;
            end
            S_BLANK: begin
               if (!bus.EN) begin
                  r_state <= S_IDLE;
                  r_sel   <= '1;
                  r_stdig <= 4'b0000;
                  r_idx   <= '0;
                  r_cnt   <= '0;
               end else if (r_cnt == C_BLK_END) begin
                  r_state <= S_SHOW;
                  r_cnt   <= '0;
                  r_stdig <= w_pat;
                  r_sel   <= w_dark ? '1 : w_sel_on;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_SHOW: begin
               if (!bus.EN) begin
                  r_state <= S_IDLE;
                  r_sel   <= '1;
                  r_stdig <= 4'b0000;
                  r_idx   <= '0;
                  r_cnt   <= '0;
               end else if (r_cnt == C_PRE_END) begin
                  r_state <= S_BLANK;
                  r_cnt   <= '0;
                  r_sel   <= '1;
                  if (r_idx == C_IDX_END) begin
                     r_idx  <= '0;
                     r_done <= 1'b1;
`ifdef STATUS_SCAN_BLINK_EN
                     if (r_frm == C_FRM_END) begin
                        r_frm   <= '0;
                        r_phase <= ~r_phase;
                     end else begin
                        r_frm <= r_frm + 1'b1;
                     end
`endif
                  end else begin
                     r_idx <= r_idx + 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.STDIG     = r_stdig;
   assign bus.DIG_SEL   = r_sel;
   assign bus.SCAN_DONE = r_done;

endmodule

// File: tb/tb_status_scan_ctrl.sv
// Directed bench for status_scan_ctrl: N_DIG=4, PRESCALE=4, BLANK_CYC=1.
// Blink section runs only when STATUS_SCAN_BLINK_EN is defined.
module tb_status_scan_ctrl;

   logic CLK = 1'b0;
   logic RST = 1'b1;

   int n_chk = 0;
   int n_err = 0;

   logic [3:0] pat [4] = '{4'b0111, 4'b0101, 4'b0011, 4'b0001};

   status_scan_ctrl_if #(.N_DIG(4)) bus ();

   status_scan_ctrl #(
      .N_DIG(4),
      .PRESCALE(4),
      .BLANK_CYC(1)
`ifdef STATUS_SCAN_BLINK_EN
      , .BLINK_FRAMES(2)
`endif
   ) dut (
      .CLK(CLK),
      .RST(RST),
      .bus(bus)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   function automatic logic [3:0] exp_sel(int t);
      logic [3:0] one;
      one = 4'b0001;
      if (t % 5 == 0) return 4'b1111;
      return ~(one << ((t / 5) % 4));
   endfunction

   initial begin
      bus.EN   = 1'b0;
      bus.LOAD = 1'b0;
      bus.STD  = '0;
`ifdef STATUS_SCAN_BLINK_EN
      bus.BLINK = '0;
`endif
      tick();
      tick();
      RST = 1'b0;

      // reset / idle
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("idle_sel", bus.DIG_SEL, 4'b1111);
         chk("idle_dig", bus.STDIG, 4'b0000);
         chk("idle_done", bus.SCAN_DONE, 1'b0);
      end

      bus.LOAD = 1'b1;
      bus.STD  = 8'b11_10_01_00;
      tick();
      bus.LOAD = 1'b0;
      chk("load_idle_sel", bus.DIG_SEL, 4'b1111);
      bus.EN = 1'b1;
      tick();

      // t counts cycles since EN was first sampled
      for (int t = 0; t <= 77; t++) begin
         chk("scan_sel", bus.DIG_SEL, exp_sel(t));
         chk("scan_done", bus.SCAN_DONE, (t > 0 && t % 20 == 0));
         if (t % 5 != 0)
            chk("scan_dig", bus.STDIG,
                (t >= 50) ? 4'b0001 : pat[(t / 5) % 4]);
         if (t == 47) begin
            bus.LOAD = 1'b1;
            bus.STD  = 8'hFF;
         end
         if (t == 48) bus.LOAD = 1'b0;
         if (t == 77) bus.EN = 1'b0;
         tick();
      end

      chk("endrop_sel", bus.DIG_SEL, 4'b1111);
      chk("endrop_dig", bus.STDIG, 4'b0000);
      chk("endrop_done", bus.SCAN_DONE, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("endrop_nodone", bus.SCAN_DONE, 1'b0);
         chk("endrop_idle", bus.DIG_SEL, 4'b1111);
      end

      bus.LOAD = 1'b1;
      bus.STD  = 8'b11_10_01_00;
      tick();
      bus.LOAD = 1'b0;
      bus.EN   = 1'b1;
      tick();
      chk("reen_blank", bus.DIG_SEL, 4'b1111);
      bus.LOAD = 1'b1;
      bus.STD  = 8'b11_10_01_11;
      tick();
      bus.LOAD = 1'b0;
      chk("reen_sel", bus.DIG_SEL, 4'b1110);
      chk("bypass_dig", bus.STDIG, 4'b0001);
      tick();
      chk("show2_sel", bus.DIG_SEL, 4'b1110);

      #2;
      RST = 1'b1;
      #1;
      chk("arst_sel", bus.DIG_SEL, 4'b1111);
      chk("arst_dig", bus.STDIG, 4'b0000);
      chk("arst_done", bus.SCAN_DONE, 1'b0);
      tick();
      RST = 1'b0;
      tick();
      chk("post_rst_blank", bus.DIG_SEL, 4'b1111);
      tick();
      chk("post_rst_sel", bus.DIG_SEL, 4'b1110);
      chk("post_rst_dig", bus.STDIG, 4'b0111);

`ifdef STATUS_SCAN_BLINK_EN
      bus.EN = 1'b0;
      RST = 1'b1;
      tick();
      RST = 1'b0;
      bus.LOAD  = 1'b1;
      bus.STD   = 8'h00;
      bus.BLINK = 4'b0100;
      tick();
      bus.LOAD = 1'b0;
      bus.EN   = 1'b1;
      tick();
      for (int t = 0; t < 120; t++) begin
         if ((t / 5) % 4 == 2 && t % 5 != 0)
            chk("blink_sel", bus.DIG_SEL,
                (t / 20 == 2 || t / 20 == 3) ? 4'b1111 : 4'b1011);
         else
            chk("blink_other", bus.DIG_SEL, exp_sel(t));
         tick();
      end
`endif

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
